accu_group: RTL and testbench

Parametrised group accumulator on a valid/ready stream. It sums up to `GROUP` consecutive input samples, or fewer when `last_a` closes a group early. Each sum is emitted as one output beat together with its sample count. It sits between a sample producer and a downstream consumer that may apply backpressure, and sustains one input sample per cycle with no inter-group bubble.

---
 rtl/accu_group.sv | 84 ++++++++
 tb/tb_accu_group.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/accu_group.sv
// Group accumulator on a valid/ready stream: sums up to GROUP samples, or
// fewer when last_a closes the group, and emits each sum with its sample count.
module accu_group #(
  parameter int DATA_W = 8,
  parameter int GROUP  = 4,
  parameter int SIGNED = 0,
  localparam int OUT_W = DATA_W + $clog2(GROUP),
  localparam int CNT_W = $clog2(GROUP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_a,
  input  logic              last_a,
  output logic              ready_a,
  output logic              valid_b,
  input  logic              ready_b,
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  count_out
);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cout_q, cout_d;
  logic             vb_q, vb_d;

  logic             acc_in, xfer_b, close, sx;
  logic [OUT_W-1:0] ext, sum;

  // The output register frees up in the same cycle it is drained, so a new
  // sample can be taken without a bubble between groups.
  assign ready_a = ~rst & (~vb_q | ready_b);
  assign acc_in  = valid_a & ready_a;
  assign xfer_b  = vb_q & ready_b;

  assign sx    = (SIGNED != 0) && data_in[DATA_W-1];
  assign ext   = {{(OUT_W-DATA_W){sx}}, data_in};
  assign sum   = ((cnt_q == '0) ? '0 : acc_q) + ext;
  assign close = (cnt_q == CNT_W'(GROUP - 1)) | last_a;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    cout_d = cout_q;
    vb_d   = vb_q;
    if (xfer_b)
      vb_d = 1'b0;
    if (acc_in) begin
      if (close) begin
        dout_d = sum;
        cout_d = cnt_q + CNT_W'(1);
        vb_d   = 1'b1;
        cnt_d  = '0;
        acc_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      cout_q <= '0;
      vb_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      cout_q <= cout_d;
      vb_q   <= vb_d;
    end
  end

  assign valid_b   = vb_q;
  assign data_out  = dout_q;
  assign count_out = cout_q;

endmodule

// File: tb/tb_accu_group.sv
// Directed bench for accu_group: default, signed GROUP=3 and GROUP=5 instances.
module tb_accu_group;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u0: defaults (OUT_W=10, CNT_W=3)
  logic [7:0] d0; logic va0, la0, ra0, vb0, rb0; logic [9:0] do0; logic [2:0] co0;
  // u1: SIGNED=1, GROUP=3 (OUT_W=10, CNT_W=2)
  logic [7:0] d1; logic va1, la1, ra1, vb1, rb1; logic [9:0] do1; logic [1:0] co1;
  // u2: DATA_W=4, GROUP=5 (OUT_W=7, CNT_W=3)
  logic [3:0] d2; logic va2, la2, ra2, vb2, rb2; logic [6:0] do2; logic [2:0] co2;

  accu_group u0 (.clk(clk), .rst(rst), .data_in(d0), .valid_a(va0), .last_a(la0),
                 .ready_a(ra0), .valid_b(vb0), .ready_b(rb0), .data_out(do0), .count_out(co0));
  accu_group #(.DATA_W(8), .GROUP(3), .SIGNED(1)) u1 (
                 .clk(clk), .rst(rst), .data_in(d1), .valid_a(va1), .last_a(la1),
                 .ready_a(ra1), .valid_b(vb1), .ready_b(rb1), .data_out(do1), .count_out(co1));
  accu_group #(.DATA_W(4), .GROUP(5), .SIGNED(0)) u2 (
                 .clk(clk), .rst(rst), .data_in(d2), .valid_a(va2), .last_a(la2),
                 .ready_a(ra2), .valid_b(vb2), .ready_b(rb2), .data_out(do2), .count_out(co2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send0(input logic [7:0] d, input logic l);
    d0 = d; va0 = 1'b1; la0 = l;
    step();
    va0 = 1'b0; la0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d);
    d1 = d; va1 = 1'b1; la1 = 1'b0;
    step();
    va1 = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d);
    d2 = d; va2 = 1'b1; la2 = 1'b0;
    step();
    va2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d0 = '0; va0 = 0; la0 = 0; rb0 = 0;
    d1 = '0; va1 = 0; la1 = 0; rb1 = 0;
    d2 = '0; va2 = 0; la2 = 0; rb2 = 0;
    step(); step();

    // reset state
    chk("rst_ready_a", ra0, 0);
    chk("rst_valid_b", vb0, 0);
    chk("rst_data_out", do0, 0);
    chk("rst_count_out", co0, 0);
    rst = 1'b0; #1;
    chk("post_rst_ready_a", ra0, 1);

    // unsigned 10,20,30,40 with ready_b=1
    rb0 = 1'b1;
    send0(8'd10, 0); send0(8'd20, 0); send0(8'd30, 0);
    chk("grp1_not_yet", vb0, 0);
    send0(8'd40, 0);
    chk("grp1_valid", vb0, 1);
    chk("grp1_sum", do0, 100);
    chk("grp1_cnt", co0, 4);

    // 8 x 255 back-to-back: results on the 4th and 8th beat, no stall
    for (int i = 0; i < 8; i++) begin
      chk("stream_ready_a", ra0, 1);
      send0(8'd255, 0);
      if (i == 3 || i == 7) begin
        chk("stream_valid", vb0, 1);
        chk("stream_sum", do0, 1020);
        chk("stream_cnt", co0, 4);
      end else begin
        chk("stream_idle", vb0, 0);
      end
    end

    // early close 5,6(last) then 1,1,1,1
    send0(8'd5, 0);
    chk("early_drain", vb0, 0);
    send0(8'd6, 1);
    chk("early_valid", vb0, 1);
    chk("early_sum", do0, 11);
    chk("early_cnt", co0, 2);
    send0(8'd1, 0); send0(8'd1, 0); send0(8'd1, 0); send0(8'd1, 0);
    chk("after_early_sum", do0, 4);
    chk("after_early_cnt", co0, 4);
    step();
    chk("drained", vb0, 0);

    // backpressure: complete 7,8,9,10 with ready_b low, then hold 5 cycles
    rb0 = 1'b0; #1;
    chk("bp_ready_free", ra0, 1);
    send0(8'd7, 0); send0(8'd8, 0); send0(8'd9, 0); send0(8'd10, 0);
    chk("bp_valid", vb0, 1);
    chk("bp_sum", do0, 34);
    d0 = 8'd50; va0 = 1'b1; la0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready_low", ra0, 0);
      chk("bp_valid_hold", vb0, 1);
      chk("bp_sum_hold", do0, 34);
      chk("bp_cnt_hold", co0, 4);
    end
    // release with a pending single-sample closing beat
    rb0 = 1'b1; #1;
    chk("bp_release_ready", ra0, 1);
    step();
    va0 = 1'b0; la0 = 1'b0;
    chk("bp_overlap_valid", vb0, 1);
    chk("bp_overlap_sum", do0, 50);
    chk("bp_overlap_cnt", co0, 1);
    step();
    chk("bp_drained", vb0, 0);

    // reset mid-group
    send0(8'd100, 0); send0(8'd100, 0);
    rst = 1'b1; #1;
    chk("midrst_ready_a", ra0, 0);
    step();
    chk("midrst_valid", vb0, 0);
    chk("midrst_data", do0, 0);
    chk("midrst_cnt", co0, 0);
    chk("midrst_ready_hold", ra0, 0);
    rst = 1'b0;
    send0(8'd1, 0); send0(8'd1, 0); send0(8'd1, 0); send0(8'd1, 0);
    chk("postrst_sum", do0, 4);
    chk("postrst_cnt", co0, 4);

    // signed GROUP=3
    rb1 = 1'b1;
    send1(8'h80); send1(8'h80); send1(8'h80);
    chk("sgn_valid", vb1, 1);
    chk("sgn_neg_sum", do1, 10'h280);
    chk("sgn_neg_cnt", co1, 3);
    send1(8'd127); send1(8'hFF); send1(8'd0);
    chk("sgn_mix_sum", do1, 126);
    chk("sgn_mix_cnt", co1, 3);

    // GROUP=5, DATA_W=4
    rb2 = 1'b1;
    for (int i = 0; i < 4; i++) send2(4'd15);
    chk("g5_not_yet", vb2, 0);
    send2(4'd15);
    chk("g5_valid", vb2, 1);
    chk("g5_sum", do2, 75);
    chk("g5_cnt", co2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
